evt_kernel_loader: RTL and testbench

EVT_KERNEL_LOADER -- requirements
Module: evt_kernel_loader

---
 rtl/evt_kernel_loader.sv | 175 +++++++++++++++++
 tb/tb_evt_kernel_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_kernel_loader.sv
// Purpose : streams kernel weights from a valid/ready event port into kernel memory.
//           The main banks take 4*CHANNEL_NUMBER words, then the residual bank takes CHANNEL_NUMBER/2 words.
// Latency : one cycle from an accepted word to its registered write. done_o follows the last write strobe by one cycle.
// Backpr. : evt_ready_o is a pure function of FSM state. A word is taken only on evt_valid_i && evt_ready_o,
//           and gaps stall the counter.
// Ports   : clk_i/rst_ni (sync, active-low) | start_i, abort_i control | evt_data_i/evt_valid_i/evt_ready_o stream
//           wr_en_o/wr_addr_o/wr_data_o/mode_o kernel-memory write | busy_o, done_o, checksum_o status
// Config  : define EVT_KERNEL_LOADER_CHECKSUM_EN to build the XOR checksum accumulator (otherwise checksum_o = 0).
module evt_kernel_loader #(
    parameter int CHANNEL_NUMBER = 64,
    parameter int DATA_WIDTH     = 32,
    localparam int ADDR_WIDTH    = $clog2(CHANNEL_NUMBER) + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] evt_data_i,
    input  logic                  evt_valid_i,
    output logic                  evt_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [1:0]            mode_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    localparam logic [ADDR_WIDTH-1:0] MAIN_LAST = ADDR_WIDTH'(4 * CHANNEL_NUMBER - 1);
    localparam logic [ADDR_WIDTH-1:0] RES_LAST  = ADDR_WIDTH'(CHANNEL_NUMBER / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_MAIN = 2'b01;
    localparam logic [1:0] MODE_RES  = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_MAIN = 2'd1,
        LOAD_RES  = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  ready;
    logic                  hs;

    // Ready comes from state only, so it never loops back through evt_valid_i.
    assign ready = (state_q == LOAD_MAIN) || (state_q == LOAD_RES);
    assign hs    = evt_valid_i && ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mode_d    = MODE_IDLE;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_MAIN;
                    cnt_d   = '0;
                end
            end
            LOAD_MAIN: begin
                // mode is registered alongside the write, so it stays 01 for the last main word
                // even though the FSM has already moved on to LOAD_RES.
                mode_d = MODE_MAIN;
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = evt_data_i;
                    if (cnt_q == MAIN_LAST) begin
                        state_d = LOAD_RES;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            LOAD_RES: begin
                mode_d = MODE_RES;
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = evt_data_i;
                    if (cnt_q == RES_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            DONE: begin
                // The last residual write is on the bus during this cycle.
                // The done pulse is registered so that it lands one cycle after that write.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a handshake in the same cycle.
        if (abort_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
            mode_d    = MODE_IDLE;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mode_q    <= MODE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
        end
    end

`ifdef EVT_KERNEL_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_q;
    logic                  accept;

    assign accept = hs && !abort_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chk_q <= '0;
        end else if ((state_q == IDLE) && start_i && !abort_i) begin
            chk_q <= '0;
        end else if (accept) begin
            chk_q <= chk_q ^ evt_data_i;
        end
    end

    assign checksum_o = chk_q;
`else
    assign checksum_o = '0;
`endif

    assign evt_ready_o = ready;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign mode_o      = mode_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_evt_kernel_loader.sv
// Purpose : directed self-checking bench for evt_kernel_loader (CHANNEL_NUMBER=64, DATA_WIDTH=32).
// Latency : writes are logged on the falling edge, and inputs are driven 1 time unit after the rising edge.
// Backpr. : the stimulus task advances to the next word only after a sampled valid && ready handshake.
module tb_evt_kernel_loader;

    localparam int CN   = 64;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int NMAIN = 4 * CN;
    localparam int NRES  = CN / 2;
    localparam int NTOT  = NMAIN + NRES;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic [DW-1:0] evt_data_i;
    logic          evt_valid_i;
    logic          evt_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [1:0]    mode_o;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] checksum_o;

    always #5 clk_i = ~clk_i;

    evt_kernel_loader #(.CHANNEL_NUMBER(CN), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .evt_data_i  (evt_data_i),
        .evt_valid_i (evt_valid_i),
        .evt_ready_o (evt_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .mode_o      (mode_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .checksum_o  (checksum_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write and done monitor
    logic [1:0]    wm[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (wr_en_o === 1'b1) begin
            wm.push_back(mode_o);
            wa.push_back(wr_addr_o);
            wd.push_back(wr_data_o);
            last_wr_cyc = cyc;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [DW-1:0] word_of(input int pat, input int i);
        if (pat == 0) return DW'(i);
        if (i == 0) return 32'hA5A5A5A5;
        if (i == 1) return 32'h0F0F0F0F;
        return '0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Sends words first..first+n-1, optionally with valid toggling every cycle.
    task automatic send(input int pat, input int first, input int n, input bit gaps, output int busy_low);
        int  i;
        int  c;
        bit  acc;
        i = first;
        c = 0;
        busy_low = 0;
        while (i < first + n && c < 3 * n + 20) begin
            evt_valid_i = gaps ? ((c % 2) == 0) : 1'b1;
            evt_data_i  = word_of(pat, i);
            @(negedge clk_i);
            acc = evt_valid_i && evt_ready_o;
            if (busy_o !== 1'b1) busy_low++;
            @(posedge clk_i);
            #1;
            if (acc) i++;
            c++;
        end
        evt_valid_i = 1'b0;
        chk("accepted_words", 64'(i - first), 64'(n));
    endtask

    task automatic check_full(input string tag, input int base);
        int nw;
        logic [1:0] em;
        logic [AW-1:0] ea;
        nw = wa.size() - base;
        chk({tag, "_count"}, 64'(nw), 64'(NTOT));
        for (int k = 0; k < NTOT && k < nw; k++) begin
            em = (k < NMAIN) ? 2'b01 : 2'b10;
            ea = (k < NMAIN) ? AW'(k) : AW'(k - NMAIN);
            chk({tag, "_wr"}, {22'b0, wm[base+k], wa[base+k], wd[base+k]},
                {22'b0, em, ea, DW'(k)});
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 64'(evt_ready_o), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
        chk({tag, "_addr"}, 64'(wr_addr_o), 64'd0);
        chk({tag, "_data"}, 64'(wr_data_o), 64'd0);
        chk({tag, "_mode"}, 64'(mode_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_csum"}, 64'(checksum_o), 64'd0);
    endtask

    int base, dc0, bl;
    logic [DW-1:0] exp_csum;

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        evt_data_i = '0; evt_valid_i = 1'b0;
`ifdef EVT_KERNEL_LOADER_CHECKSUM_EN
        exp_csum = 32'hAAAAAAAA;
`else
        exp_csum = 32'h0;
`endif
        idle(3);
        check_reset("reset");
        rst_ni = 1'b1;
        idle(2);

        // Back-to-back full load
        base = wa.size(); dc0 = done_cnt;
        pulse_start();
        chk("a_busy_after_start", 64'(busy_o), 64'd1);
        chk("a_ready_after_start", 64'(evt_ready_o), 64'd1);
        send(0, 0, NTOT, 1'b0, bl);
        idle(4);
        check_full("a", base);
        chk("a_done_cnt", 64'(done_cnt - dc0), 64'd1);
        chk("a_done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
        chk("a_busy_end", 64'(busy_o), 64'd0);
        chk("a_addr_hold", 64'(wr_addr_o), 64'd31);
        chk("a_data_hold", 64'(wr_data_o), 64'd287);
        chk("a_csum_count_pattern", 64'(checksum_o), 64'd0);

        // Full load with valid toggling every cycle
        base = wa.size(); dc0 = done_cnt;
        pulse_start();
        send(0, 0, NTOT, 1'b1, bl);
        chk("b_busy_low_cycles", 64'(bl), 64'd0);
        idle(4);
        check_full("b", base);
        chk("b_done_cnt", 64'(done_cnt - dc0), 64'd1);

        // Abort after 100 words, with a same-cycle handshake offered
        base = wa.size(); dc0 = done_cnt;
        pulse_start();
        send(0, 0, 100, 1'b0, bl);
        evt_valid_i = 1'b1; evt_data_i = 32'd100; abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0; evt_valid_i = 1'b0;
        chk("c_busy_after_abort", 64'(busy_o), 64'd0);
        chk("c_ready_after_abort", 64'(evt_ready_o), 64'd0);
        idle(3);
        chk("c_write_count", 64'(wa.size() - base), 64'd100);
        chk("c_last_addr", 64'(wa[wa.size()-1]), 64'd99);
        chk("c_done_never", 64'(done_cnt - dc0), 64'd0);
        base = wa.size();
        pulse_start();
        evt_valid_i = 1'b1; evt_data_i = 32'h55;
        @(posedge clk_i); #1;
        evt_valid_i = 1'b0;
        idle(1);
        chk("c_restart_count", 64'(wa.size() - base), 64'd1);
        chk("c_restart_wr", {22'b0, wm[base], wa[base], wd[base]}, {22'b0, 2'b01, 8'd0, 32'h55});
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;

        // start_i pulsed during LOAD_RES is ignored
        base = wa.size(); dc0 = done_cnt;
        pulse_start();
        send(0, 0, NMAIN + 4, 1'b0, bl);
        pulse_start();
        chk("d_busy_in_res", 64'(busy_o), 64'd1);
        send(0, NMAIN + 4, NRES - 4, 1'b0, bl);
        idle(4);
        check_full("d", base);
        chk("d_done_cnt", 64'(done_cnt - dc0), 64'd1);

        // Checksum pattern
        base = wa.size();
        pulse_start();
        send(1, 0, NTOT, 1'b0, bl);
        idle(4);
        chk("e_write_count", 64'(wa.size() - base), 64'(NTOT));
        chk("e_first_data", 64'(wd[base]), 64'hA5A5A5A5);
        chk("e_checksum_held", 64'(checksum_o), 64'(exp_csum));
        pulse_start();
        chk("e_checksum_cleared", 64'(checksum_o), 64'd0);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;

        // Reset in the middle of LOAD_MAIN
        base = wa.size();
        pulse_start();
        send(0, 0, 50, 1'b0, bl);
        evt_valid_i = 1'b1; evt_data_i = 32'd50; rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check_reset("f_rst_mid");
        rst_ni = 1'b1;
        idle(5);
        evt_valid_i = 1'b0;
        idle(2);
        chk("f_write_count", 64'(wa.size() - base), 64'd50);
        chk("f_busy_after", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
